// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared widths, FSM encoding and saturating-increment helper
package product_accumulator_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int GUARD_DEF = 8;
    localparam int LEN_W_DEF = 8;

    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    // Supports counter widths up to 32 bits
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] mx;
        mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= mx) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product-in / result-out handshake bundle
interface product_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int GUARD = 8,
    parameter int LEN_W = 8
);
    import product_accumulator_pkg::*;
    localparam int ACC_W = acc_width(WIDTH, GUARD);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_product;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic [LEN_W-1:0]     out_count;
    logic                 out_overflow;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );
    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: W-bit ripple-carry adder with carry in/out
module ripple_carry_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] sum,
    output logic         carry_out
);
    logic c;
    always_comb begin
        c = carry_in;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of multiplier products and presents sum/count/overflow
// on a held result; in_last closes a sum, clear aborts it.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    product_accumulator_if.slave bus
);
    localparam int ACC_W = acc_width(WIDTH, GUARD);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, sum_q, sum_d, add_sum;
    logic [LEN_W-1:0]   count_q, count_d, out_count_q, out_count_d, count_inc;
    logic               ovf_q, ovf_d, out_ovf_q, out_ovf_d, carry_out, xfer;

    ripple_carry_adder #(.W(ACC_W)) u_add (
        .a         (acc_q),
        .b         ({{GUARD{1'b0}}, bus.in_product}),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (carry_out)
    );

    assign count_inc        = LEN_W'(sat_inc(32'(count_q), LEN_W));
    assign bus.in_ready     = (state_q == ST_ACCUM) && !clear;
    assign bus.out_valid    = (state_q == ST_HOLD);
    assign bus.out_sum      = sum_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_ovf_q;
    assign xfer             = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (xfer && bus.in_last) begin
            // Closing beat: publish the updated totals and start the next sum from zero
            sum_d       = add_sum;
            out_count_d = count_inc;
            out_ovf_d   = ovf_q | carry_out;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = ST_HOLD;
        end else if (xfer) begin
            acc_d   = add_sum;
            count_d = count_inc;
            ovf_d   = ovf_q | carry_out;
        end else if (state_q == ST_HOLD && bus.out_ready) begin
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the narrow array multiplier's `2*WIDTH`-bit product. It accepts a stream of products over a valid/ready handshake and sums them into an unsigned accumulator with guard bits. When a beat flagged `in_last` arrives, it presents the sum, beat count and overflow flag on a valid/ready output. It turns the combinational multiplier into a dot-product / multiply-accumulate datapath.

## Interface
- `WIDTH`, 16, logical multiplier operand width; the product input is `2*WIDTH` bits.
- `GUARD`, 8, extra accumulator MSBs; `ACC_W = 2*WIDTH+GUARD`.
- `LEN_W`, 8, width of the beat counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous abort: discard the partial sum and any held result.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can take a beat.
- `in_product`  in  `2*WIDTH`  unsigned product from the multiplier.
- `in_last`  in  1  beat is the final term of the current sum.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `ACC_W`  accumulated sum, modulo `2^ACC_W`.
- `out_count`  out  `LEN_W`  beats in the sum, saturating at `2^LEN_W-1`.
- `out_overflow`  out  1  sticky: a carry out of bit `ACC_W-1` occurred during the sum.

## Operation
- Two-state FSM:
  - ACCUM: `in_ready = !clear`, `out_valid = 0`.
  - HOLD: `in_ready = 0`, `out_valid = 1`.
- Input transfer: `in_valid && in_ready`.
  - On transfer, `acc <= acc + in_product`, zero-extended to `ACC_W`.
  - On transfer, `count <= sat(count+1)`.
  - On transfer, `ovf <= ovf | carry_out`.
- Transfer with `in_last = 1`:
  - The updated acc/count/ovf are loaded into the output registers.
  - FSM goes to HOLD.
  - The working acc/count/ovf are zeroed in the same edge.
- HOLD with `out_ready = 1`: FSM returns to ACCUM. Output registers keep their last values; only `out_valid` drops.
- `clear = 1` takes priority over everything:
  - Working acc/count/ovf go to 0 and the FSM goes to ACCUM.
  - Any beat presented in that cycle is not accepted (`in_ready` is already 0).
- A single-beat sum (first beat has `in_last = 1`) is legal: `out_count = 1`.
- Overflow: the sum wraps modulo `2^ACC_W` and `out_overflow` is set for that result. The flag clears for the next sum.
- Count saturation does not set overflow.
- No input combinational path to any output except `in_ready` from `clear`.

## Timing
- Reset values:
  - `out_valid = 0`, `in_ready = 1`.
  - `out_sum = 0`, `out_count = 0`, `out_overflow = 0`.
  - FSM in ACCUM.
  - Reset takes effect asynchronously, mid-sum or mid-HOLD.
- Latency: an `in_last` transfer at edge t gives `out_valid = 1` from t until the consumer handshake.
- Outputs are stable while `out_valid && !out_ready`.
- Throughput:
  - One beat per cycle within a sum.
  - One bubble per result minimum: the HOLD cycle, plus any out-side stall.
- A new sum's first beat can be accepted the cycle after the output handshake.
- `clear` in HOLD drops `out_valid` on the next edge; the result is lost.

## Structure
- Shared package holds:
  - `ACC_W` derivation.
  - FSM state encoding (`ST_ACCUM`, `ST_HOLD`).
  - Saturating-increment helper function.
- Accumulation adder: one instance of the existing `ripple_carry_adder` at width `ACC_W`.
  - `carry_in = 0`.
  - `a = acc`, `b = {GUARD'b0, in_product}`.
  - `carry_out` feeds the overflow logic.
- FSM and registers live in this module; no other sub-modules.

## Test plan
All cases use `WIDTH=16`, `GUARD=8`, `LEN_W=8`.
1. Reset:
   - Stimulus: `rst_n` low, then high.
   - Required: `in_ready = 1`, `out_valid = 0`, `out_sum = 0`, `out_count = 0`, `out_overflow = 0`.
   - Also drop `rst_n` mid-sum: outputs return to these values with no clock edge.
2. Basic sum:
   - Stimulus: beats 3, 5, 7 with `in_last` on 7.
   - Required: next cycle `out_valid = 1`, `out_sum = 15`, `out_count = 3`, `out_overflow = 0`.
3. Backpressure:
   - Stimulus: hold `out_ready = 0` for 4 cycles after case 2.
   - Required: outputs stable and `in_ready = 0`.
   - Then `out_ready = 1` for one cycle, then a beat 4 with `in_last`.
   - Required: `out_sum = 4`, `out_count = 1`.
4. Overflow:
   - Stimulus: 257 beats of `0xFFFE0001`, last flagged.
   - Required: `out_sum = 0x00FDFE0101`, `out_count = 255`, `out_overflow = 1`.
   - Following sum of a single beat 1: `out_overflow = 0`.
5. Clear mid-sum:
   - Stimulus: beats 10, 20; then `clear = 1` with `in_valid = 1` and beat 99; then beat 9 with `in_last`.
   - Required: `in_ready = 0` during clear, `out_sum = 9`, `out_count = 1`.
6. Clear in HOLD:
   - Stimulus: after case 2, assert `clear` while `out_valid = 1`, `out_ready = 0`.
   - Required: `out_valid = 0` next cycle, `in_ready = 1` after `clear` drops.
